// File: rtl/blit_scheduler_pkg.sv
// Shared definitions for the blit scheduler.
//   - BLIT_OP_* operation codes understood by the blitter
//   - command field widths and the packed command word layout
//   - scheduler FSM state encodings
package blit_scheduler_pkg;

  localparam logic [2:0] BLIT_OP_SPRITE      = 3'd0;
  localparam logic [2:0] BLIT_OP_CLEAR       = 3'd1;
  localparam logic [2:0] BLIT_OP_FILL        = 3'd2;
  localparam logic [2:0] BLIT_OP_SCROLL_UP   = 3'd3;
  localparam logic [2:0] BLIT_OP_SCROLL_DOWN = 3'd4;
  localparam logic [2:0] BLIT_OP_COPY        = 3'd5;

  localparam int OP_W     = 3;
  localparam int SRC_W    = 12;
  localparam int HEIGHT_W = 4;
  localparam int DESTX_W  = 7;
  localparam int DESTY_W  = 6;
  localparam int CMD_W    = 1 + OP_W + SRC_W + HEIGHT_W + DESTX_W + DESTY_W;

  // Bit positions (LSB first): desty [5:0], destx [12:6], height [16:13],
  // src [28:17], op [31:29], sync [32].
  typedef struct packed {
    logic                sync;
    logic [OP_W-1:0]     op;
    logic [SRC_W-1:0]    src;
    logic [HEIGHT_W-1:0] height;
    logic [DESTX_W-1:0]  destx;
    logic [DESTY_W-1:0]  desty;
  } cmd_t;

  typedef enum logic [1:0] {
    BS_IDLE      = 2'd0,
    BS_WAIT_VB   = 2'd1,
    BS_ISSUE     = 2'd2,
    BS_WAIT_DONE = 2'd3
  } bs_state_t;

endpackage

// File: rtl/blit_cmd_fifo.sv
// Synchronous command FIFO.
//   clk, reset      : clock, synchronous active-high reset
//   push, push_data : write request/data; ignored when full unless popping
//   pop, pop_data   : read request; pop_data shows the head (first-word fall-through)
//   flush           : empties the FIFO; wins over a same-cycle push
//   count/full/empty: occupancy
module blit_cmd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop) && !flush;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/blit_scheduler.sv
// Blit command scheduler: queues CPU blit commands and issues them one at a
// time to the blitter over its enable/ready handshake. Commands flagged sync
// are held until vertical blank.
//   clk, reset        : system clock, synchronous active-high reset
//   req_*             : CPU command interface (valid/ready)
//   vblank_async      : vertical blank from the VGA clock domain
//   blit_*            : command to blitter; blit_enable held until ready low
//   flush             : drop queued (not in-flight) commands
//   busy, count       : activity / queued entries
//   err_timeout       : sticky, blitter never acknowledged an enable
//
// state        | meaning
// BS_IDLE      | waiting for a queued command and an idle blitter
// BS_WAIT_VB   | sync command registered, waiting for vblank
// BS_ISSUE     | blit_enable high, waiting for blit_ready to fall
// BS_WAIT_DONE | blitter busy, waiting for blit_ready to return
module blit_scheduler
  import blit_scheduler_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [11:0]            req_src,
  input  logic [3:0]             req_height,
  input  logic [6:0]             req_destX,
  input  logic [5:0]             req_destY,
  input  logic                   req_sync,
  input  logic                   vblank_async,
  output logic [2:0]             blit_op,
  output logic [11:0]            blit_src,
  output logic [3:0]             blit_srcHeight,
  output logic [6:0]             blit_destX,
  output logic [5:0]             blit_destY,
  output logic                   blit_enable,
  input  logic                   blit_ready,
  input  logic                   flush,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_timeout
);

  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 1);

  bs_state_t        state;
  bs_state_t        state_nxt;
  cmd_t             push_cmd;
  cmd_t             head_cmd;
  logic [CMD_W-1:0] fifo_dout;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             vb_meta;
  logic             vblank_s;
  logic [TW-1:0]    tmr;
  logic             timeout_hit;

  assign push_cmd = '{sync: req_sync, op: req_op, src: req_src, height: req_height,
                      destx: req_destX, desty: req_destY};
  assign head_cmd = cmd_t'(fifo_dout);

  assign req_ready = !fifo_full;
  // Gate with req_ready so a command is stored only when the CPU sees the
  // handshake complete.
  assign fifo_push = req_valid && req_ready;

  blit_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .flush     (flush),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vb_meta  <= 1'b0;
      vblank_s <= 1'b0;
    end else begin
      vb_meta  <= vblank_async;
      vblank_s <= vb_meta;
    end
  end

  assign timeout_hit = (state == BS_ISSUE) && blit_ready && (tmr == '0);

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      BS_IDLE: begin
        if (!fifo_empty && blit_ready) begin
          fifo_pop  = 1'b1;
          state_nxt = head_cmd.sync ? BS_WAIT_VB : BS_ISSUE;
        end
      end
      BS_WAIT_VB: begin
        if (vblank_s) state_nxt = BS_ISSUE;
      end
      BS_ISSUE: begin
        // An acknowledge on the terminal cycle still counts as an acknowledge.
        if (!blit_ready)      state_nxt = BS_WAIT_DONE;
        else if (tmr == '0)   state_nxt = BS_IDLE;
      end
      BS_WAIT_DONE: begin
        if (blit_ready) state_nxt = BS_IDLE;
      end
      default: state_nxt = BS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= BS_IDLE;
      blit_enable    <= 1'b0;
      err_timeout    <= 1'b0;
      tmr            <= '0;
      blit_op        <= '0;
      blit_src       <= '0;
      blit_srcHeight <= '0;
      blit_destX     <= '0;
      blit_destY     <= '0;
    end else begin
      state       <= state_nxt;
      blit_enable <= (state_nxt == BS_ISSUE);
      if (timeout_hit) err_timeout <= 1'b1;

      if ((state_nxt == BS_ISSUE) && (state != BS_ISSUE)) tmr <= TMR_LOAD;
      else if ((state == BS_ISSUE) && (tmr != '0))        tmr <= tmr - 1'b1;

      if (fifo_pop) begin
        blit_op        <= head_cmd.op;
        blit_src       <= head_cmd.src;
        blit_srcHeight <= head_cmd.height;
        blit_destX     <= head_cmd.destx;
        blit_destY     <= head_cmd.desty;
      end
    end
  end

  assign busy = (count != '0) || (state != BS_IDLE);

endmodule

// File: tb/tb_blit_scheduler.sv
module tb_blit_scheduler;
  import blit_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_src = '0;
  logic [3:0]  req_height = '0;
  logic [6:0]  req_destX = '0;
  logic [5:0]  req_destY = '0;
  logic        req_sync = 1'b0;
  logic        vblank_async = 1'b0;
  logic [2:0]  blit_op;
  logic [11:0] blit_src;
  logic [3:0]  blit_srcHeight;
  logic [6:0]  blit_destX;
  logic [5:0]  blit_destY;
  logic        blit_enable;
  logic        blit_ready = 1'b1;
  logic        flush = 1'b0;
  logic        busy;
  logic [2:0]  count;
  logic        err_timeout;

  blit_scheduler #(.DEPTH(4), .ACK_TIMEOUT(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_src        (req_src),
    .req_height     (req_height),
    .req_destX      (req_destX),
    .req_destY      (req_destY),
    .req_sync       (req_sync),
    .vblank_async   (vblank_async),
    .blit_op        (blit_op),
    .blit_src       (blit_src),
    .blit_srcHeight (blit_srcHeight),
    .blit_destX     (blit_destX),
    .blit_destY     (blit_destY),
    .blit_enable    (blit_enable),
    .blit_ready     (blit_ready),
    .flush          (flush),
    .busy           (busy),
    .count          (count),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int n_issued = 0;
  cmd_t sb[$];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic cmd_t mk(input logic [2:0] op, input logic [11:0] src, input logic [3:0] h,
                              input logic [6:0] x, input logic [5:0] y, input logic s);
    cmd_t c;
    c.sync = s; c.op = op; c.src = src; c.height = h; c.destx = x; c.desty = y;
    return c;
  endfunction

  // Blitter model: mode 0 acknowledges ack_dly cycles after seeing enable and
  // stays busy hold_cyc cycles; mode 1 never acknowledges; hold_low forces busy.
  int mode = 0;
  int ack_dly = 3;
  int hold_cyc = 20;
  bit hold_low = 1'b0;
  int phase = 0;
  int mk_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (hold_low) begin
      blit_ready = 1'b0;
      phase = 0;
    end else if (phase == 0) begin
      blit_ready = 1'b1;
      if (blit_enable && mode == 0) begin
        phase = 1;
        mk_cnt = ack_dly;
      end
    end else if (phase == 1) begin
      mk_cnt--;
      if (mk_cnt == 0) begin
        blit_ready = 1'b0;
        phase = 2;
        mk_cnt = hold_cyc;
      end
    end else begin
      mk_cnt--;
      if (mk_cnt == 0) begin
        blit_ready = 1'b1;
        phase = 0;
      end
    end
  end

  // Scoreboard: each accepted command must appear on the blit_* outputs, in
  // order, when blit_enable rises.
  bit en_prev = 1'b0;
  always @(negedge clk) begin
    if (blit_enable && !en_prev && !reset) begin
      cmd_t e;
      n_issued++;
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("issue_cmd", {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY},
              {e.op, e.src, e.height, e.destx, e.desty});
      end
    end
    en_prev = blit_enable;
  end

  // Drives one command at a negedge, returns at the following negedge.
  task automatic push_cmd(input cmd_t c, input bit do_flush, output bit acc);
    req_valid = 1'b1;
    req_sync = c.sync; req_op = c.op; req_src = c.src;
    req_height = c.height; req_destX = c.destx; req_destY = c.desty;
    flush = do_flush;
    acc = req_ready;
    if (acc && !do_flush) sb.push_back(c);
    @(posedge clk);
    if (do_flush) sb.delete();
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    for (int i = 0; i < lim && busy; i++) @(negedge clk);
    check(nm, 64'(busy), 64'd0);
  endtask

  typedef struct {
    cmd_t c;
    bit   exp_ready;
    int   exp_count;
  } vec_t;

  vec_t tbl[5];

  initial begin
    bit acc;
    int k;
    int issued_snap;

    tbl[0] = '{mk(BLIT_OP_SPRITE,      12'h101, 4'd1, 7'd10, 6'd1, 1'b0), 1'b1, 1};
    tbl[1] = '{mk(BLIT_OP_CLEAR,       12'h202, 4'd2, 7'd20, 6'd2, 1'b0), 1'b1, 2};
    tbl[2] = '{mk(BLIT_OP_FILL,        12'h303, 4'd3, 7'd30, 6'd3, 1'b0), 1'b1, 3};
    tbl[3] = '{mk(BLIT_OP_COPY,        12'h404, 4'd4, 7'd40, 6'd4, 1'b0), 1'b1, 4};
    tbl[4] = '{mk(BLIT_OP_SCROLL_UP,   12'h505, 4'd5, 7'd50, 6'd5, 1'b0), 1'b0, 4};

    // reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    check("rst_enable", 64'(blit_enable), 64'd0);
    check("rst_data", {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY}, 64'd0);
    repeat (3) @(negedge clk);
    check("idle_empty_no_enable", 64'(blit_enable), 64'd0);

    // single sprite
    push_cmd(mk(BLIT_OP_SPRITE, 12'h050, 4'd5, 7'd1, 6'd1, 1'b0), 1'b0, acc);
    check("t1_accept", 64'(acc), 64'd1);
    check("t1_en_cycle1", 64'(blit_enable), 64'd0);
    check("t1_count_cycle1", 64'(count), 64'd1);
    @(negedge clk);
    check("t1_en_cycle2", 64'(blit_enable), 64'd1);
    check("t1_count_cycle2", 64'(count), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    k = 1;
    while (blit_enable && k < 100) begin
      @(negedge clk);
      if (blit_enable) k++;
    end
    check("t1_enable_width", 64'(k), 64'd4);
    for (int i = 0; i < 100 && !blit_ready; i++) @(negedge clk);
    check("t1_ready_back", 64'(blit_ready), 64'd1);
    check("t1_busy_until_sampled", 64'(busy), 64'd1);
    check("t1_src_stable", 64'(blit_src), 64'h050);
    @(negedge clk);
    check("t1_busy_fall", 64'(busy), 64'd0);

    // fill and overflow with the blitter held busy
    hold_low = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) begin
      push_cmd(tbl[i].c, 1'b0, acc);
      check($sformatf("t2_accept_%0d", i), 64'(acc), 64'(tbl[i].exp_ready));
      check($sformatf("t2_count_%0d", i), 64'(count), 64'(tbl[i].exp_count));
    end
    check("t2_req_ready_full", 64'(req_ready), 64'd0);
    check("t2_no_issue_while_busy", 64'(blit_enable), 64'd0);
    issued_snap = n_issued;
    ack_dly = 3;
    hold_cyc = 2;
    hold_low = 1'b0;
    wait_idle("t2_drain_done", 400);
    check("t2_issued_four", 64'(n_issued - issued_snap), 64'd4);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // vblank hold
    hold_cyc = 20;
    push_cmd(mk(BLIT_OP_SCROLL_DOWN, 12'h000, 4'd0, 7'd0, 6'd2, 1'b1), 1'b0, acc);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (blit_enable) k++;
    end
    check("t3_held_no_enable", 64'(k), 64'd0);
    check("t3_busy_held", 64'(busy), 64'd1);
    vblank_async = 1'b1;
    k = 0;
    while (!blit_enable && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t3_vblank_latency", 64'(k), 64'd3);
    wait_idle("t3_done", 200);
    vblank_async = 1'b0;
    repeat (3) @(negedge clk);

    // timeout: blitter never acknowledges
    mode = 1;
    push_cmd(mk(BLIT_OP_FILL, 12'hABC, 4'd7, 7'd99, 6'd33, 1'b0), 1'b0, acc);
    push_cmd(mk(BLIT_OP_COPY, 12'h123, 4'd8, 7'd12, 6'd44, 1'b0), 1'b0, acc);
    check("t4_enable_up", 64'(blit_enable), 64'd1);
    k = 0;
    while (!err_timeout && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t4_timeout_cycle", 64'(k), 64'd64);
    check("t4_enable_dropped", 64'(blit_enable), 64'd0);
    @(negedge clk);
    check("t4_next_issues", 64'(blit_enable), 64'd1);
    mode = 0;
    wait_idle("t4_done", 200);
    check("t4_err_sticky", 64'(err_timeout), 64'd1);

    // flush while a command is in WAIT_DONE
    hold_cyc = 30;
    push_cmd(mk(BLIT_OP_SPRITE, 12'h777, 4'd3, 7'd5, 6'd6, 1'b0), 1'b0, acc);
    for (int i = 0; i < 50 && !blit_enable; i++) @(negedge clk);
    for (int i = 0; i < 50 && blit_enable; i++) @(negedge clk);
    check("t5_in_wait_done", 64'({blit_enable, blit_ready, busy}), 64'b001);
    push_cmd(mk(BLIT_OP_CLEAR, 12'h111, 4'd1, 7'd1, 6'd1, 1'b0), 1'b0, acc);
    push_cmd(mk(BLIT_OP_CLEAR, 12'h222, 4'd2, 7'd2, 6'd2, 1'b0), 1'b0, acc);
    push_cmd(mk(BLIT_OP_CLEAR, 12'h333, 4'd3, 7'd3, 6'd3, 1'b0), 1'b0, acc);
    check("t5_queued", 64'(count), 64'd3);
    issued_snap = n_issued;
    push_cmd(mk(BLIT_OP_FILL, 12'h444, 4'd4, 7'd4, 6'd4, 1'b0), 1'b1, acc);
    check("t5_flushed_count", 64'(count), 64'd0);
    check("t5_inflight_busy", 64'(busy), 64'd1);
    check("t5_inflight_src", 64'(blit_src), 64'h777);
    wait_idle("t5_inflight_done", 200);
    repeat (10) @(negedge clk);
    check("t5_no_more_issue", 64'(n_issued - issued_snap), 64'd0);

    // reset during ISSUE with two queued
    mode = 1;
    push_cmd(mk(BLIT_OP_SPRITE, 12'h0AA, 4'd1, 7'd1, 6'd1, 1'b0), 1'b0, acc);
    push_cmd(mk(BLIT_OP_SPRITE, 12'h0BB, 4'd2, 7'd2, 6'd2, 1'b0), 1'b0, acc);
    push_cmd(mk(BLIT_OP_SPRITE, 12'h0CC, 4'd3, 7'd3, 6'd3, 1'b0), 1'b0, acc);
    check("t6_issuing", 64'({blit_enable, count}), 64'({1'b1, 3'd2}));
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_enable", 64'(blit_enable), 64'd0);
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_err", 64'(err_timeout), 64'd0);
    check("t6_rst_data", {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY}, 64'd0);
    sb.delete();
    reset = 1'b0;
    mode = 0;
    @(negedge clk);
    check("t6_req_ready_after", 64'(req_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/blit_scheduler.md
Name: blit_scheduler

Overview:
Queues blit commands from the CPU and issues them one at a time to the blitter over its enable/ready handshake. Sits between the cpu and blitter instances at the top level, in the main clk domain.
Commands flagged sync are held until vertical blank, so scrolls and clears do not tear.
Removes the need for the CPU to halt on !blit_ready for every draw.

Parameters:
DEPTH, 4, command FIFO entries (power of two, 2..16)
ACK_TIMEOUT, 64, clk cycles allowed for blit_ready to fall after blit_enable rises

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
req_valid  in  1  CPU presents a command
req_ready  out  1  FIFO can accept; transfer when req_valid && req_ready
req_op  in  3  blit operation (BLIT_OP_* codes)
req_src  in  12  sprite source address in CPU RAM
req_height  in  4  sprite height
req_destX  in  7  destination X
req_destY  in  6  destination Y / scroll amount
req_sync  in  1  hold command until vblank
vblank_async  in  1  vOutside from the vgaClk domain (asynchronous)
blit_op  out  3  to blitter
blit_src  out  12  to blitter
blit_srcHeight  out  4  to blitter
blit_destX  out  7  to blitter
blit_destY  out  6  to blitter
blit_enable  out  1  to blitter; held until blit_ready is seen low
blit_ready  in  1  from blitter; high = idle
flush  in  1  drop all queued (not in-flight) commands
busy  out  1  FIFO non-empty or command in flight
count  out  $clog2(DEPTH)+1  queued entries
err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset values:
  - req_ready=1 (from the cycle after reset deasserts), busy=0, count=0, err_timeout=0, blit_enable=0.
  - All blit_* data outputs = 0.
  - FSM=IDLE; synchronizer flops=0.
- Reset mid-blit: the in-flight command is abandoned. The blitter finishes on its own; the scheduler does not wait.
- Command word is 33 bits: {sync, op, src, height, destX, destY}.
- FIFO:
  - req_ready = (count != DEPTH).
  - A push when full is ignored.
  - Simultaneous push and pop when full is allowed: count is unchanged and the new word is stored.
  - Pointers wrap modulo DEPTH.
- vblank_async passes through a 2-flop synchronizer, giving vblank_s with 2 cycles of latency.
- FSM:
  - IDLE: if FIFO non-empty and blit_ready=1, pop the head into the output registers.
    - sync=1 -> WAIT_VB.
    - sync=0 -> ISSUE.
  - WAIT_VB: stay until vblank_s=1, then -> ISSUE. Data outputs are already stable.
  - ISSUE: blit_enable=1 and the timeout counter runs.
    - If blit_ready=0 is sampled: blit_enable=0 on the next edge, -> WAIT_DONE.
    - If the counter reaches ACK_TIMEOUT-1 with blit_ready still 1: set err_timeout, drop blit_enable, -> IDLE. The command is treated as completed.
  - WAIT_DONE: when blit_ready=1 -> IDLE.
- Latency: with a non-empty FIFO, sync=0 and blit_ready=1, blit_enable rises 2 cycles after the push (1 cycle into the FIFO, 1 cycle to pop and register).
- blit_* data outputs change only on pop, and stay stable throughout ISSUE and WAIT_DONE.
- flush:
  - Empties the FIFO on the next edge and wins over a same-cycle push; that push is lost.
  - Does not affect a command in WAIT_VB, ISSUE or WAIT_DONE.
- busy = (count != 0) || (state != IDLE).
- An empty FIFO in IDLE drives nothing; blit_enable stays 0.

Decomposition:
- blitter.vh holds:
  - the existing BLIT_OP_* codes;
  - the command field widths and bit offsets (CMD_W=33 and the field positions);
  - the FSM state encodings (BS_IDLE, BS_WAIT_VB, BS_ISSUE, BS_WAIT_DONE).
- Sub-module blit_cmd_fifo: synchronous FIFO, parameterized width and depth, with push/pop/flush/count/full/empty.
- The synchronizer is inline (2 flops).

Test Plan:
- Single sprite: push op=SPRITE, src=0x050, h=5, X=1, Y=1, sync=0; blitter model drops ready 3 cycles after enable and holds it low 20 cycles -> blit_enable high exactly 4 cycles (1 to register, 3 to ready-low) starting cycle 2 after push; outputs match pushed values; busy falls the cycle after ready returns.
- Fill and overflow, DEPTH=4: push 5 commands back-to-back with blit_ready=0 -> req_ready low after 4th; 5th not accepted; count=4; on ready=1 all 4 issue in push order.
- Vblank hold: push SCROLL_DOWN, Y=2, sync=1 with vblank_async=0 -> stays WAIT_VB and blit_enable=0 for 100 cycles; raise vblank -> blit_enable rises exactly 3 cycles later.
- Timeout: blitter model never drops ready after enable -> err_timeout set at cycle ACK_TIMEOUT=64 after enable rise; next queued command still issues.
- Flush: queue 3 commands while first is in WAIT_DONE, assert flush together with a push -> count=0 next cycle; in-flight command completes; no further blit_enable.
- Reset mid-issue: assert reset during ISSUE with 2 queued -> next cycle blit_enable=0, count=0, busy=0, err_timeout=0.
